// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared frame-width default and FSM state encoding for spi_slave
package spi_slave_pkg;

  localparam int unsigned SPI_DW          = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - multi-flop synchronizer with rise/fall edge detection
//   clk_i, rst_i : clock, synchronous active-high reset
//   d_i          : asynchronous input
//   q_o          : synchronized level
//   rise_o/fall_o: one-cycle pulses on edges of the synchronized level
module spi_slave_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave with one-entry TX buffer and RX valid/ready output
//   clk, rst                 : system clock, synchronous active-high reset
//   spi_sck_i/mosi_i/cs_i    : asynchronous SPI inputs (CS active low)
//   spi_miso_o/spi_miso_oe_o : slave data out and its output enable
//   tx_data_i/valid_i/ready_o: TX byte handshake into the one-entry buffer
//   rx_data_o/valid_o/ready_i: received byte handshake
//   rx_overrun_o/tx_underrun_o: one-cycle error pulses
//   busy_o                   : frame selected
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned DW          = SPI_DW,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_sck_i,
  input  logic          spi_mosi_i,
  input  logic          spi_cs_i,
  output logic          spi_miso_o,
  output logic          spi_miso_oe_o,
  input  logic [DW-1:0] tx_data_i,
  input  logic          tx_valid_i,
  output logic          tx_ready_o,
  output logic [DW-1:0] rx_data_o,
  output logic          rx_valid_o,
  input  logic          rx_ready_i,
  output logic          rx_overrun_o,
  output logic          tx_underrun_o,
  output logic          busy_o
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  logic sck_rise, sck_fall, mosi_q, cs_q, cs_fall;
  logic unused_sck_q, unused_mosi_rise, unused_mosi_fall, unused_cs_rise;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk), .rst_i(rst), .d_i(spi_sck_i),
    .q_o(unused_sck_q), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk), .rst_i(rst), .d_i(spi_mosi_i),
    .q_o(mosi_q), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(clk), .rst_i(rst), .d_i(spi_cs_i),
    .q_o(cs_q), .rise_o(unused_cs_rise), .fall_o(cs_fall)
  );

  spi_state_e    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-2:0] rx_shift_q, rx_shift_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          buf_valid_q, buf_valid_d;
  logic          tx_udr_q, tx_udr_d;
  logic          load_pend_q, load_pend_d;
  logic          tx_load;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = 1'b0;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    tx_udr_d    = 1'b0;
    load_pend_d = load_pend_q;
    tx_load     = 1'b0;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_ACTIVE;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          tx_load     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_q) begin
          // Abort: partial RX bits are simply never delivered, shifter contents dropped.
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          tx_shift_d  = '0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = (rx_shift_q << 1) | (DW-1)'(mosi_q);
            if (bit_cnt_q == CW'(DW - 1)) begin
              bit_cnt_d   = '0;
              load_pend_d = 1'b1;
              rx_data_d   = {rx_shift_q, mosi_q};
              rx_valid_d  = 1'b1;
              rx_ovr_d    = rx_valid_q && !rx_ready_i;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          // The falling edge that closes a byte reloads instead of shifting.
          if (sck_fall) begin
            if (load_pend_q) begin
              tx_load     = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loads look only at the registered buffer; a byte accepted this same
    // cycle lands in the buffer for the next load.
    if (tx_load) begin
      if (buf_valid_q) begin
        tx_shift_d = buf_q;
      end else begin
        tx_shift_d = '0;
        tx_udr_d   = 1'b1;
      end
      buf_valid_d = 1'b0;
    end

    if (tx_valid_i && !buf_valid_q) begin
      buf_d       = tx_data_i;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      tx_udr_q    <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      tx_udr_q    <= tx_udr_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign busy_o        = (state_q == ST_ACTIVE);
  assign spi_miso_oe_o = busy_o;
  assign spi_miso_o    = busy_o & tx_shift_q[DW-1];
  assign tx_ready_o    = ~buf_valid_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_ovr_q;
  assign tx_underrun_o = tx_udr_q;

endmodule
